// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - RV32I pipelined control path: decode, ID/EX, EX/MEM, MEM/WB control registers
module ctrl_pipe #(
    parameter bit EN_UPPER = 1'b1,
    parameter bit EN_JALR  = 1'b1,
    parameter int RA_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      op_d,
    input  logic [RA_W-1:0] rs1_d,
    input  logic [RA_W-1:0] rs2_d,
    input  logic [RA_W-1:0] rd_d,
    input  logic            flush_e,
    output logic [2:0]      imm_src_d,
    output logic            stall_d,
    output logic            reg_write_e,
    output logic            alu_src_e,
    output logic            alu_src_a_e,
    output logic            mem_write_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic            jalr_e,
    output logic            illegal_e,
    output logic [1:0]      alu_op_e,
    output logic [1:0]      result_src_e,
    output logic [RA_W-1:0] rd_e,
    output logic            reg_write_m,
    output logic            mem_write_m,
    output logic [1:0]      result_src_m,
    output logic [RA_W-1:0] rd_m,
    output logic            reg_write_w,
    output logic [1:0]      result_src_w,
    output logic [RA_W-1:0] rd_w
);

    logic       dec_reg_write;
    logic       dec_alu_src;
    logic       dec_alu_src_a;
    logic       dec_mem_write;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_jalr;
    logic       dec_illegal;
    logic [1:0] dec_alu_op;
    logic [1:0] dec_result_src;
    logic [2:0] dec_imm_src;
    logic       load_use;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_alu_src_a  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_jalr       = 1'b0;
        dec_illegal    = 1'b0;
        dec_alu_op     = 2'b00;
        dec_result_src = 2'b00;
        dec_imm_src    = 3'b000;
        case (op_d)
            7'b0110011: begin
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
            end
            7'b0010011: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 2'b10;
            end
            7'b0000011: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b01;
            end
            7'b0100011: begin
                dec_imm_src   = 3'b001;
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            7'b1100011: begin
                dec_imm_src = 3'b010;
                dec_branch  = 1'b1;
                dec_alu_op  = 2'b01;
            end
            7'b1101111: begin
                dec_reg_write  = 1'b1;
                dec_imm_src    = 3'b011;
                dec_result_src = 2'b10;
                dec_jump       = 1'b1;
            end
            7'b1100111: begin
                if (EN_JALR) begin
                    dec_reg_write  = 1'b1;
                    dec_alu_src    = 1'b1;
                    dec_result_src = 2'b10;
                    dec_jump       = 1'b1;
                    dec_jalr       = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            // LUI bypasses the ALU entirely, so its operand select is left at 0
            7'b0110111: begin
                if (EN_UPPER) begin
                    dec_reg_write  = 1'b1;
                    dec_imm_src    = 3'b100;
                    dec_result_src = 2'b11;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0010111: begin
                if (EN_UPPER) begin
                    dec_reg_write = 1'b1;
                    dec_imm_src   = 3'b100;
                    dec_alu_src   = 1'b1;
                    dec_alu_src_a = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign imm_src_d = dec_imm_src;

    // The bubble inserted on stall clears result_src_e, so a stall never lasts past one cycle
    assign load_use = (result_src_e == 2'b01) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign stall_d  = load_use;

    always_ff @(posedge clk) begin
        if (rst || flush_e || stall_d) begin
            reg_write_e  <= 1'b0;
            alu_src_e    <= 1'b0;
            alu_src_a_e  <= 1'b0;
            mem_write_e  <= 1'b0;
            branch_e     <= 1'b0;
            jump_e       <= 1'b0;
            jalr_e       <= 1'b0;
            illegal_e    <= 1'b0;
            alu_op_e     <= 2'b00;
            result_src_e <= 2'b00;
            rd_e         <= '0;
        end else begin
            reg_write_e  <= dec_reg_write;
            alu_src_e    <= dec_alu_src;
            alu_src_a_e  <= dec_alu_src_a;
            mem_write_e  <= dec_mem_write;
            branch_e     <= dec_branch;
            jump_e       <= dec_jump;
            jalr_e       <= dec_jalr;
            illegal_e    <= dec_illegal;
            alu_op_e     <= dec_alu_op;
            result_src_e <= dec_result_src;
            rd_e         <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            rd_m         <= '0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            rd_w         <= '0;
        end else begin
            reg_write_m  <= reg_write_e;
            mem_write_m  <= mem_write_e;
            result_src_m <= result_src_e;
            rd_m         <= rd_e;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed self-checking bench for ctrl_pipe (full and minimal decode variants)
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op_d;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       flush_e;

    logic [2:0] imm_src_d, n_imm_src_d;
    logic       stall_d, n_stall_d;
    logic       reg_write_e, alu_src_e, alu_src_a_e, mem_write_e, branch_e, jump_e, jalr_e, illegal_e;
    logic       n_reg_write_e, n_alu_src_e, n_alu_src_a_e, n_mem_write_e, n_branch_e, n_jump_e, n_jalr_e, n_illegal_e;
    logic [1:0] alu_op_e, result_src_e, n_alu_op_e, n_result_src_e;
    logic [4:0] rd_e, rd_m, rd_w, n_rd_e, n_rd_m, n_rd_w;
    logic       reg_write_m, mem_write_m, reg_write_w, n_reg_write_m, n_mem_write_m, n_reg_write_w;
    logic [1:0] result_src_m, result_src_w, n_result_src_m, n_result_src_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.EN_UPPER(1'b1), .EN_JALR(1'b1), .RA_W(5)) u_dut (
        .clk(clk), .rst(rst), .op_d(op_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .flush_e(flush_e), .imm_src_d(imm_src_d), .stall_d(stall_d),
        .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .alu_src_a_e(alu_src_a_e),
        .mem_write_e(mem_write_e), .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
        .illegal_e(illegal_e), .alu_op_e(alu_op_e), .result_src_e(result_src_e), .rd_e(rd_e),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
        .rd_m(rd_m), .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w)
    );

    ctrl_pipe #(.EN_UPPER(1'b0), .EN_JALR(1'b0), .RA_W(5)) u_dut_min (
        .clk(clk), .rst(rst), .op_d(op_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .flush_e(flush_e), .imm_src_d(n_imm_src_d), .stall_d(n_stall_d),
        .reg_write_e(n_reg_write_e), .alu_src_e(n_alu_src_e), .alu_src_a_e(n_alu_src_a_e),
        .mem_write_e(n_mem_write_e), .branch_e(n_branch_e), .jump_e(n_jump_e), .jalr_e(n_jalr_e),
        .illegal_e(n_illegal_e), .alu_op_e(n_alu_op_e), .result_src_e(n_result_src_e), .rd_e(n_rd_e),
        .reg_write_m(n_reg_write_m), .mem_write_m(n_mem_write_m), .result_src_m(n_result_src_m),
        .rd_m(n_rd_m), .reg_write_w(n_reg_write_w), .result_src_w(n_result_src_w), .rd_w(n_rd_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic fl);
        op_d = op; rs1_d = rs1; rs2_d = rs2; rd_d = rd; flush_e = fl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(7'b0110011, 5'd1, 5'd2, 5'd3, 1'b0);
        tick(); tick();
        checks++; if (reg_write_e !== 1'b0) begin errors++; $display("FAIL reset_reg_write_e got %0h exp 0", reg_write_e); end
        checks++; if (rd_e !== 5'd0) begin errors++; $display("FAIL reset_rd_e got %0h exp 0", rd_e); end
        checks++; if (result_src_e !== 2'b00) begin errors++; $display("FAIL reset_result_src_e got %0h exp 0", result_src_e); end
        checks++; if (reg_write_m !== 1'b0 || reg_write_w !== 1'b0) begin errors++; $display("FAIL reset_reg_write_mw got %0h%0h exp 00", reg_write_m, reg_write_w); end
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL reset_stall_d got %0h exp 0", stall_d); end
        checks++; if (illegal_e !== 1'b0) begin errors++; $display("FAIL reset_illegal_e got %0h exp 0", illegal_e); end
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        drive(7'b0110011, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        checks++; if (reg_write_e !== 1'b1) begin errors++; $display("FAIL r_reg_write_e got %0h exp 1", reg_write_e); end
        checks++; if (alu_op_e !== 2'b10) begin errors++; $display("FAIL r_alu_op_e got %0h exp 2", alu_op_e); end
        checks++; if (rd_e !== 5'd5) begin errors++; $display("FAIL r_rd_e got %0h exp 5", rd_e); end
        checks++; if (alu_src_e !== 1'b0) begin errors++; $display("FAIL r_alu_src_e got %0h exp 0", alu_src_e); end
        drive(7'b0010011, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        checks++; if (reg_write_m !== 1'b1 || rd_m !== 5'd5) begin errors++; $display("FAIL r_mem got rw=%0h rd=%0h exp rw=1 rd=5", reg_write_m, rd_m); end
        checks++; if (alu_src_e !== 1'b1) begin errors++; $display("FAIL i_alu_src_e got %0h exp 1", alu_src_e); end
        tick();
        checks++; if (reg_write_w !== 1'b1 || rd_w !== 5'd5) begin errors++; $display("FAIL r_wb got rw=%0h rd=%0h exp rw=1 rd=5", reg_write_w, rd_w); end
    endtask

    task automatic test_load_use();
        drive(7'b0000011, 5'd1, 5'd2, 5'd7, 1'b0);
        tick();
        checks++; if (result_src_e !== 2'b01) begin errors++; $display("FAIL lw_result_src_e got %0h exp 1", result_src_e); end
        drive(7'b0110011, 5'd7, 5'd3, 5'd9, 1'b0);
        checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h exp 1", stall_d); end
        tick();
        checks++; if (reg_write_e !== 1'b0 || rd_e !== 5'd0) begin errors++; $display("FAIL lu_bubble got rw=%0h rd=%0h exp 0 0", reg_write_e, rd_e); end
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_release got %0h exp 0", stall_d); end
        checks++; if (result_src_m !== 2'b01 || rd_m !== 5'd7) begin errors++; $display("FAIL lu_mem got rs=%0h rd=%0h exp 1 7", result_src_m, rd_m); end
        tick();
        checks++; if (rd_e !== 5'd9 || reg_write_e !== 1'b1) begin errors++; $display("FAIL lu_resume got rd=%0h rw=%0h exp 9 1", rd_e, reg_write_e); end
        drive(7'b0100011, 5'd0, 5'd9, 5'd0, 1'b0);
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_not_load got %0h exp 0", stall_d); end
        drive(7'b0000011, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(7'b0110011, 5'd0, 5'd0, 5'd4, 1'b0);
        checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_rd0 got %0h exp 0", stall_d); end
        tick();
    endtask

    task automatic test_branch();
        drive(7'b1100011, 5'd1, 5'd2, 5'd0, 1'b1);
        checks++; if (imm_src_d !== 3'b010) begin errors++; $display("FAIL br_imm_src got %0h exp 2", imm_src_d); end
        tick();
        checks++; if (branch_e !== 1'b0 || mem_write_e !== 1'b0 || alu_op_e !== 2'b00) begin errors++; $display("FAIL br_flush got b=%0h mw=%0h op=%0h exp 0 0 0", branch_e, mem_write_e, alu_op_e); end
        drive(7'b0100011, 5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        checks++; if (mem_write_e !== 1'b0) begin errors++; $display("FAIL sw_flush got %0h exp 0", mem_write_e); end
        drive(7'b1100011, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        checks++; if (branch_e !== 1'b1 || alu_op_e !== 2'b01 || reg_write_e !== 1'b0) begin errors++; $display("FAIL br_pass got b=%0h op=%0h rw=%0h exp 1 1 0", branch_e, alu_op_e, reg_write_e); end
    endtask

    task automatic test_upper();
        drive(7'b0110111, 5'd0, 5'd0, 5'd4, 1'b0);
        checks++; if (imm_src_d !== 3'b100) begin errors++; $display("FAIL lui_imm_src got %0h exp 4", imm_src_d); end
        checks++; if (n_imm_src_d !== 3'b000) begin errors++; $display("FAIL lui_off_imm_src got %0h exp 0", n_imm_src_d); end
        tick();
        checks++; if (result_src_e !== 2'b11 || reg_write_e !== 1'b1 || illegal_e !== 1'b0) begin errors++; $display("FAIL lui got rs=%0h rw=%0h il=%0h exp 3 1 0", result_src_e, reg_write_e, illegal_e); end
        checks++; if (n_illegal_e !== 1'b1 || n_reg_write_e !== 1'b0 || n_result_src_e !== 2'b00) begin errors++; $display("FAIL lui_off got il=%0h rw=%0h rs=%0h exp 1 0 0", n_illegal_e, n_reg_write_e, n_result_src_e); end
        drive(7'b0010111, 5'd0, 5'd0, 5'd6, 1'b0);
        tick();
        checks++; if (alu_src_a_e !== 1'b1 || alu_src_e !== 1'b1 || result_src_e !== 2'b00 || rd_e !== 5'd6) begin errors++; $display("FAIL auipc got a=%0h b=%0h rs=%0h rd=%0h exp 1 1 0 6", alu_src_a_e, alu_src_e, result_src_e, rd_e); end
        checks++; if (n_alu_src_a_e !== 1'b0 || n_illegal_e !== 1'b1) begin errors++; $display("FAIL auipc_off got a=%0h il=%0h exp 0 1", n_alu_src_a_e, n_illegal_e); end
    endtask

    task automatic test_jumps();
        drive(7'b1100111, 5'd1, 5'd0, 5'd1, 1'b0);
        tick();
        checks++; if (jump_e !== 1'b1 || jalr_e !== 1'b1 || result_src_e !== 2'b10 || alu_src_e !== 1'b1) begin errors++; $display("FAIL jalr got j=%0h jr=%0h rs=%0h as=%0h exp 1 1 2 1", jump_e, jalr_e, result_src_e, alu_src_e); end
        checks++; if (n_jump_e !== 1'b0 || n_jalr_e !== 1'b0 || n_illegal_e !== 1'b1) begin errors++; $display("FAIL jalr_off got j=%0h jr=%0h il=%0h exp 0 0 1", n_jump_e, n_jalr_e, n_illegal_e); end
        drive(7'b1101111, 5'd0, 5'd0, 5'd1, 1'b0);
        checks++; if (imm_src_d !== 3'b011) begin errors++; $display("FAIL jal_imm_src got %0h exp 3", imm_src_d); end
        tick();
        checks++; if (jump_e !== 1'b1 || jalr_e !== 1'b0 || result_src_e !== 2'b10) begin errors++; $display("FAIL jal got j=%0h jr=%0h rs=%0h exp 1 0 2", jump_e, jalr_e, result_src_e); end
        drive(7'b1111111, 5'd0, 5'd0, 5'd8, 1'b0);
        checks++; if (imm_src_d !== 3'b000) begin errors++; $display("FAIL ill_imm_src got %0h exp 0", imm_src_d); end
        tick();
        checks++; if (illegal_e !== 1'b1 || reg_write_e !== 1'b0 || jump_e !== 1'b0 || alu_op_e !== 2'b00 || result_src_e !== 2'b00 || mem_write_e !== 1'b0) begin errors++; $display("FAIL illegal got il=%0h rw=%0h j=%0h op=%0h rs=%0h mw=%0h exp 1 0 0 0 0 0", illegal_e, reg_write_e, jump_e, alu_op_e, result_src_e, mem_write_e); end
    endtask

    task automatic test_mid_reset();
        drive(7'b0110011, 5'd1, 5'd2, 5'd6, 1'b0);
        tick();
        drive(7'b0100011, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        checks++; if (mem_write_e !== 1'b1 || reg_write_m !== 1'b1) begin errors++; $display("FAIL pre_rst got mw_e=%0h rw_m=%0h exp 1 1", mem_write_e, reg_write_m); end
        rst = 1'b1;
        tick();
        checks++; if (mem_write_m !== 1'b0 || reg_write_w !== 1'b0) begin errors++; $display("FAIL mid_rst got mw_m=%0h rw_w=%0h exp 0 0", mem_write_m, reg_write_w); end
        checks++; if (reg_write_e !== 1'b0 || mem_write_e !== 1'b0 || reg_write_m !== 1'b0 || rd_m !== 5'd0 || rd_w !== 5'd0 || stall_d !== 1'b0) begin errors++; $display("FAIL mid_rst_all got rw_e=%0h mw_e=%0h rw_m=%0h rd_m=%0h rd_w=%0h st=%0h exp all 0", reg_write_e, mem_write_e, reg_write_m, rd_m, rd_w, stall_d); end
        rst = 1'b0;
        drive(7'b0110011, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        checks++; if (reg_write_e !== 1'b1 || rd_e !== 5'd3) begin errors++; $display("FAIL post_rst got rw=%0h rd=%0h exp 1 3", reg_write_e, rd_e); end
    endtask

    initial begin
        rst = 1'b1;
        op_d = 7'd0; rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0; flush_e = 1'b0;
        test_reset();
        test_rtype();
        test_load_use();
        test_branch();
        test_upper();
        test_jumps();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
